tt_um_divider: RTL and testbench

TT_UM_DIVIDER -- requirements
Module: tt_um_divider

---
 rtl/div_pkg.sv | 42 ++++
 rtl/div_core.sv | 76 +++++++
 rtl/tt_um_divider.sv | 134 +++++++++++++
 tb/tb_tt_um_divider.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types, widths and iteration step for the divider (DIV_RADIX4_EN selects 4 iterations)
package div_pkg;

  localparam int DATA_W = 8;
`ifdef DIV_RADIX4_EN
  localparam int ITERS = 4;
`else
  localparam int ITERS = 8;
`endif
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'b00,
    CMD_LOAD_LO = 2'b01,
    CMD_LOAD_HI = 2'b10,
    CMD_START   = 2'b11
  } cmd_t;

  // One restoring-division step: shift the next dividend bit into the partial
  // remainder, subtract the divisor when it fits, shift the quotient bit in.
  // Returns {remainder, quotient/dividend shift register}.
  function automatic logic [2*DATA_W-1:0] div_step(
    input logic [DATA_W-1:0] rem,
    input logic [DATA_W-1:0] quo,
    input logic [DATA_W-1:0] dvs
  );
    logic [DATA_W:0]   trial;
    logic              fits;
    logic [DATA_W-1:0] rem_n;
    trial = {rem, quo[DATA_W-1]};
    fits  = (trial >= {1'b0, dvs});
    rem_n = fits ? (trial[DATA_W-1:0] - dvs) : trial[DATA_W-1:0];
    return {rem_n, quo[DATA_W-2:0], fits};
  endfunction

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - iterative restoring divider datapath (DIV_RADIX4_EN resolves two bits per cycle)
module div_core
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [15:0]       dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              done_o,
  output logic [DATA_W-1:0] quo_o,
  output logic [DATA_W-1:0] rem_o
);

  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [2*DATA_W-1:0] step1;
  logic [2*DATA_W-1:0] step_res;
  logic                last;

  // Combinational iteration: one or two restoring steps per cycle
  always_comb begin
    step1 = div_step(rem_q, quo_q, divisor_i);
`ifdef DIV_RADIX4_EN
    step_res = div_step(step1[2*DATA_W-1:DATA_W], step1[DATA_W-1:0], divisor_i);
`else
    step_res = step1;
`endif
  end

  assign last   = busy_q && (cnt_q == CNT_W'(ITERS - 1));
  assign done_o = last;
  assign quo_o  = step_res[DATA_W-1:0];
  assign rem_o  = step_res[2*DATA_W-1:DATA_W];

  // Next-state for shift registers and iteration counter
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      rem_d  = dividend_i[15:8];
      quo_d  = dividend_i[7:0];
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = step_res[2*DATA_W-1:DATA_W];
      quo_d = step_res[DATA_W-1:0];
      if (last) begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Working registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/tt_um_divider.sv
// rtl/tt_um_divider.sv - 16/8 unsigned divider top: pin decode, loads, start edge detect, flags, output mux (DIV_RADIX4_EN)
module tt_um_divider
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t            state_q, state_d;
  logic [15:0]       dividend_q, dividend_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic [DATA_W-1:0] quotient_q, quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        prev_cmd_q, prev_cmd_d;

  logic [1:0]        cmd;
  logic              out_sel;
  logic              start_req;
  logic              is_div0;
  logic              is_ovf;
  logic              core_start;
  logic              core_done;
  logic [DATA_W-1:0] core_quo;
  logic [DATA_W-1:0] core_rem;
  logic              busy;
  logic              done;
  logic              unused_pins;

  assign cmd         = uio_in[1:0];
  assign out_sel     = uio_in[2];
  assign unused_pins = &{1'b0, ena, uio_in[7:3]};

  assign start_req  = (cmd == CMD_START) && (prev_cmd_q != CMD_START) && (state_q != ST_CALC);
  assign is_div0    = (ui_in == '0);
  assign is_ovf     = !is_div0 && (dividend_q[15:8] >= ui_in);
  assign core_start = start_req && !is_div0 && !is_ovf;

  div_core u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (core_start),
    .dividend_i (dividend_q),
    .divisor_i  (divisor_q),
    .done_o     (core_done),
    .quo_o      (core_quo),
    .rem_o      (core_rem)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: degenerate starts finish immediately, others iterate
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_req) state_d = core_start ? ST_CALC : ST_DONE;
      ST_CALC:          if (core_done) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    busy = (state_q == ST_CALC);
    done = (state_q == ST_DONE);
  end

  // Operand loads, flag checks and result capture
  always_comb begin
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    prev_cmd_d  = cmd;
    if (state_q != ST_CALC) begin
      if (cmd == CMD_LOAD_LO) dividend_d[7:0]  = ui_in;
      if (cmd == CMD_LOAD_HI) dividend_d[15:8] = ui_in;
      if (start_req) begin
        divisor_d = ui_in;
        div0_d    = is_div0;
        ovf_d     = is_ovf;
        if (is_div0) begin
          quotient_d  = 8'hFF;
          remainder_d = dividend_q[7:0];
        end else if (is_ovf) begin
          quotient_d  = 8'hFF;
          remainder_d = 8'hFF;
        end
      end
    end else if (core_done) begin
      quotient_d  = core_quo;
      remainder_d = core_rem;
    end
  end

  // Operand, result and flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dividend_q  <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      prev_cmd_q  <= CMD_NOP;
    end else begin
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
      prev_cmd_q  <= prev_cmd_d;
    end
  end

  assign uo_out  = out_sel ? remainder_q : quotient_q;
  assign uio_out = {busy, done, div0_q, ovf_q, 3'b000, unused_pins};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_divider.sv
// tb/tb_tt_um_divider.sv - scoreboard bench for tt_um_divider (honours DIV_RADIX4_EN)
module tb_tt_um_divider;

`ifdef DIV_RADIX4_EN
  localparam int ITERS = 4;
`else
  localparam int ITERS = 8;
`endif
  localparam logic [1:0] C_NOP = 2'b00, C_LO = 2'b01, C_HI = 2'b10, C_GO = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_divider dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       div0;
    logic       ovf;
    int         lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] mdl_dvd;
  logic [1:0]  last_cmd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer division with the degenerate cases layered on top
  function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
    exp_t e;
    int a, b;
    a = int'(dvd);
    b = int'(dvs);
    e.div0 = 1'b0; e.ovf = 1'b0; e.lat = 0;
    if (b == 0) begin
      e.q = 8'hFF; e.r = dvd[7:0]; e.div0 = 1'b1;
    end else if (a / b > 255) begin
      e.q = 8'hFF; e.r = 8'hFF; e.ovf = 1'b1;
    end else begin
      e.q = 8'(a / b); e.r = 8'(a % b); e.lat = ITERS;
    end
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] cur_q = 8'h00, cur_r = 8'h00;
  logic       cur_div0 = 1'b0, cur_ovf = 1'b0;
  logic       mon_rst_pend = 1'b1;
  logic       pend_start = 1'b0;
  logic       prev_done = 1'b0;
  logic [1:0] mon_prev_cmd = 2'b00;
  int         busy_cnt = 0;

  task automatic present();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_result", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("busy_cycles", busy_cnt, e.lat);
      chk("done_on_result", uio_out[6], 1);
      cur_q = e.q; cur_r = e.r; cur_div0 = e.div0; cur_ovf = e.ovf;
    end
  endtask

  always @(negedge clk) begin
    if (mon_rst_pend) begin
      cur_q = 8'h00; cur_r = 8'h00; cur_div0 = 1'b0; cur_ovf = 1'b0;
      chk("reset_uio_out", uio_out, 8'h00);
      chk("reset_uo_out", uo_out, 8'h00);
      busy_cnt = 0;
    end else begin
      if (pend_start) begin
        busy_cnt = 0;
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else if (exp_q[0].lat == 0) present();
        else begin cur_div0 = 1'b0; cur_ovf = 1'b0; end
      end else if (uio_out[6] && !prev_done) begin
        present();
      end
      if (uio_out[7]) busy_cnt++;
      chk("uo_out", uo_out, uio_in[2] ? cur_r : cur_q);
      chk("flags", uio_out[5:4], {cur_div0, cur_ovf});
      chk("low_nibble", uio_out[3:0], 4'h0);
      chk("busy_done_excl", uio_out[7] & uio_out[6], 1'b0);
    end
    chk("uio_oe", uio_oe, 8'hF0);
    prev_done    = uio_out[6];
    mon_rst_pend = !rst_n;
    pend_start   = rst_n && (uio_in[1:0] == C_GO) && (mon_prev_cmd != C_GO) && !uio_out[7];
    mon_prev_cmd = rst_n ? uio_in[1:0] : C_NOP;
  end

  // ---------------- driver ----------------
  task automatic step(input logic [1:0] c, input logic [7:0] d);
    uio_in   = {5'($urandom), 1'($urandom), c};
    ui_in    = d;
    last_cmd = c;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    step(C_LO, v[7:0]);
    mdl_dvd[7:0] = v[7:0];
    step(C_HI, v[15:8]);
    mdl_dvd[15:8] = v[15:8];
  endtask

  task automatic do_start(input logic [7:0] dvs);
    if (last_cmd == C_GO) step(C_NOP, 8'($urandom));
    exp_q.push_back(model(mdl_dvd, dvs));
    step(C_GO, dvs);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(C_NOP, 8'($urandom));
    chk("result_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic op(input logic [15:0] dvd, input logic [7:0] dvs);
    load(dvd);
    do_start(dvs);
    wait_done();
  endtask

  initial begin
    int   rises;
    logic pb;
    logic [7:0] hi, dvs;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00; mdl_dvd = 16'h0000; last_cmd = C_NOP;
    step(C_NOP, 8'h00);
    step(C_NOP, 8'h00);
    rst_n = 1'b1;
    step(C_NOP, 8'h00);

    // Directed cases
    op(16'h1234, 8'h56);
    op(16'hFE01, 8'hFF);
    op(16'h00AB, 8'h00);
    op(16'h0200, 8'h02);
    op(16'h0200, 8'h03);

    // Reset on the third CALC cycle abandons the operation
    load(16'h0064);
    do_start(8'h07);
    step(C_NOP, 8'h00);
    step(C_NOP, 8'h00);
    rst_n = 1'b0;
    exp_q.delete();
    step(C_NOP, 8'h00);
    rst_n = 1'b1;
    mdl_dvd = 16'h0000;
    for (int i = 0; i < ITERS + 2; i++) step(C_NOP, 8'h00);
    chk("abort_no_done", uio_out[7:6], 2'b00);
    op(16'h0064, 8'h07);

    // Holding start yields one operation
    load(16'h4321);
    do_start(8'h9A);
    rises = 1;
    pb = uio_out[7];
    for (int i = 0; i < 19; i++) begin
      step(C_GO, 8'h9A);
      if (uio_out[7] && !pb) rises++;
      pb = uio_out[7];
    end
    chk("held_start_busy_intervals", rises, 1);
    step(C_NOP, 8'h00);
    wait_done();

    // Load during CALC is ignored; restart reuses the old dividend
    load(16'h1234);
    do_start(8'h56);
    step(C_LO, 8'hEE);
    wait_done();
    do_start(8'h56);
    wait_done();

    // Randomized operations
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0: load(16'($urandom));
        1: begin step(C_LO, 8'($urandom)); mdl_dvd[7:0] = ui_in; end
        2: begin step(C_HI, 8'($urandom)); mdl_dvd[15:8] = ui_in; end
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) step(C_NOP, 8'($urandom));
      hi = mdl_dvd[15:8];
      case ($urandom_range(0, 7))
        0:       dvs = 8'h00;
        1:       dvs = (hi == 8'h00) ? 8'h00 : 8'($urandom_range(1, int'(hi)));
        default: dvs = 8'($urandom_range(int'(hi) + 1 > 255 ? 255 : int'(hi) + 1, 255));
      endcase
      do_start(dvs);
      if (exp_q.size() != 0 && exp_q[0].lat != 0 && $urandom_range(0, 2) == 0)
        step($urandom_range(0, 1) ? C_LO : C_HI, 8'($urandom));
      wait_done();
    end

    step(C_NOP, 8'h00);
    step(C_NOP, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
